// File: rtl/clock_pulse_controller.sv
// clock_pulse_controller
// Turns the command interpreter's clock-control outputs (clk_enable level,
// write_pulse strobe, num_pulses count) into the registered clock-enable
// that gates the processor under test. Supports free-run, stop and exact
// N-cycle bursts, and reports burst progress and completion.
// Optional build macro: CYCLE_COUNTER_EN adds a 64-bit cycle_count output
// counting every cycle in which processor_clk_en is high.
//
// state       | meaning
// ST_STOPPED  | processor clock gated off, waiting for a request
// ST_FREE_RUN | processor clock running while clk_enable stays high
// ST_BURST    | issuing the remaining pulses of a step burst
module clock_pulse_controller #(
  parameter int PULSE_BITS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic                  write_pulse,
  input  logic [PULSE_BITS-1:0] num_pulses,
  output logic                  processor_clk_en,
  output logic                  busy,
  output logic                  pulse_done,
  output logic [PULSE_BITS-1:0] pulses_remaining
`ifdef CYCLE_COUNTER_EN
  ,
  output logic [63:0]           cycle_count
`endif
);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_FREE_RUN = 2'd1,
    ST_BURST    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  clk_en_q, clk_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [PULSE_BITS-1:0] rem_q, rem_d;

  // Next-state and next-output decode; every output is registered.
  always_comb begin
    state_d  = state_q;
    clk_en_d = clk_en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rem_d    = rem_q;
    case (state_q)
      ST_BURST: begin
        // Exit on the last pulse; treating 0 the same keeps the counter from wrapping.
        if (rem_q <= PULSE_BITS'(1)) begin
          state_d  = ST_STOPPED;
          clk_en_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          rem_d    = '0;
        end else begin
          rem_d = rem_q - PULSE_BITS'(1);
        end
      end
      default: begin
        // STOPPED and FREE_RUN share the same load rules; write_pulse wins over clk_enable.
        if (write_pulse) begin
          if (num_pulses != '0) begin
            state_d  = ST_BURST;
            clk_en_d = 1'b1;
            busy_d   = 1'b1;
            rem_d    = num_pulses;
          end else begin
            // Zero-length burst: complete immediately without issuing enable.
            state_d  = ST_STOPPED;
            clk_en_d = 1'b0;
            done_d   = 1'b1;
          end
        end else if (clk_enable) begin
          state_d  = ST_FREE_RUN;
          clk_en_d = 1'b1;
        end else begin
          state_d  = ST_STOPPED;
          clk_en_d = 1'b0;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_STOPPED;
      clk_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      clk_en_q <= clk_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rem_q    <= rem_d;
    end
  end

  assign processor_clk_en = clk_en_q;
  assign busy             = busy_q;
  assign pulse_done       = done_q;
  assign pulses_remaining = rem_q;

`ifdef CYCLE_COUNTER_EN
  logic [63:0] cycle_count_q, cycle_count_d;

  // Count cycles the processor actually ran; wraps naturally at 2^64.
  always_comb begin
    cycle_count_d = cycle_count_q + {63'd0, clk_en_q};
  end

  // Cycle counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_clock_pulse_controller.sv
// Testbench for clock_pulse_controller: directed scenarios followed by a
// randomized phase, all checked against a behavioural reference model.
module tb_clock_pulse_controller;

  localparam int PB = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_enable;
  logic          write_pulse;
  logic [PB-1:0] num_pulses;
  logic          processor_clk_en;
  logic          busy;
  logic          pulse_done;
  logic [PB-1:0] pulses_remaining;
`ifdef CYCLE_COUNTER_EN
  logic [63:0]   cycle_count;
`endif

  clock_pulse_controller #(.PULSE_BITS(PB)) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_enable       (clk_enable),
    .write_pulse      (write_pulse),
    .num_pulses       (num_pulses),
    .processor_clk_en (processor_clk_en),
    .busy             (busy),
    .pulse_done       (pulse_done),
    .pulses_remaining (pulses_remaining)
`ifdef CYCLE_COUNTER_EN
    ,
    .cycle_count      (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a burst is "pulses left to issue"; outside a burst the
  // enable simply follows clk_enable one edge later.
  logic          m_en, m_busy, m_done;
  longint        m_left;
  logic [63:0]   m_cc;

  task automatic model_edge();
    if (reset) begin
      m_en = 0; m_busy = 0; m_done = 0; m_left = 0; m_cc = 0;
    end else begin
      if (m_en) m_cc = m_cc + 64'd1;
      m_done = 0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 0; m_en = 0; m_done = 1;
        end
      end else if (write_pulse) begin
        if (num_pulses != 0) begin
          m_busy = 1; m_en = 1; m_left = longint'(num_pulses);
        end else begin
          m_en = 0; m_done = 1;
        end
      end else begin
        m_en = clk_enable;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("clk_en", {63'd0, processor_clk_en}, {63'd0, m_en});
    chk("busy", {63'd0, busy}, {63'd0, m_busy});
    chk("pulse_done", {63'd0, pulse_done}, {63'd0, m_done});
    chk("remaining", {32'd0, pulses_remaining}, 64'(m_left));
`ifdef CYCLE_COUNTER_EN
    chk("cycle_count", cycle_count, m_cc);
`endif
  endtask

  initial begin
    int en_cnt, done_cnt;
    m_en = 0; m_busy = 0; m_done = 0; m_left = 0; m_cc = 0;
    reset = 1; clk_enable = 1; write_pulse = 0; num_pulses = '0;

    // Reset with clk_enable held high, then free-run.
    repeat (3) step();
    reset = 0;
    repeat (4) step();

    // Stop, then a 5-pulse burst.
    clk_enable = 0;
    repeat (2) step();
    write_pulse = 1; num_pulses = 5;
    step();
    write_pulse = 0;
    repeat (7) step();

    // Zero-length burst.
    write_pulse = 1; num_pulses = 0;
    step();
    write_pulse = 0;
    repeat (3) step();

    // 3-pulse burst with interfering strobe and clk_enable toggling.
    write_pulse = 1; num_pulses = 3;
    step();
    write_pulse = 0;
    en_cnt = 1; done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      write_pulse = (i == 0);
      num_pulses  = 10;
      clk_enable  = (i % 2 == 0) && (i < 2);
      step();
      if (processor_clk_en) en_cnt++;
      if (pulse_done) done_cnt++;
    end
    clk_enable = 0; write_pulse = 0;
    chk("burst3_en_cycles", 64'(en_cnt), 64'd3);
    chk("burst3_done_cnt", 64'(done_cnt), 64'd1);

    // Burst of 8 with reset when two pulses remain.
    write_pulse = 1; num_pulses = 8;
    step();
    write_pulse = 0;
    for (int i = 0; i < 20 && m_left != 2; i++) step();
    reset = 1;
    step();
    chk("reset_mid_burst_done", {63'd0, pulse_done}, 64'd0);
    reset = 0;
    step();

    // Maximum count: counter must decrement from all ones without wrapping.
    write_pulse = 1; num_pulses = '1;
    step();
    write_pulse = 0;
    repeat (4) step();
    reset = 1;
    step();
    reset = 0;

`ifdef CYCLE_COUNTER_EN
    // 100 free-run cycles, stop, burst of 7.
    clk_enable = 1;
    repeat (100) step();
    clk_enable = 0;
    step();
    write_pulse = 1; num_pulses = 7;
    step();
    write_pulse = 0;
    repeat (9) step();
    reset = 1;
    step();
    reset = 0;
`endif

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 59) == 0);
      write_pulse = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) clk_enable = ~clk_enable;
      num_pulses  = ($urandom_range(0, 9) == 0) ? PB'($urandom) & 32'h7 : PB'($urandom_range(0, 6));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
